mips_run_ctrl: RTL and testbench
================================

# mips_run_ctrl

Synthesizable run-control and supervision block for the MIPS core. It sits between the board/bench clock-reset source and `mips_top`. It sequences the core's reset and bounds execution with a parametrised watchdog. It detects program completion from a memory-mapped "tohost" store or a PC self-loop, then reports a latched pass/fail/timeout verdict after a configurable drain period. It moves the bench's reset, watchdog and end-of-run logic into hardware so FPGA and simulation runs share one mechanism.

## Interface
Parameters:
- `ADDR_W`, 32, width of `pc` and `mem_addr`
- `DATA_W`, 32, width of `mem_wdata` and `result`
- `RST_HOLD`, 4, cycles `core_rst_n` is held low after `start` (≥1)
- `WDOG_CYCLES`, 100000, RUN cycles before timeout (1 … 2^32−2)
- `STALL_LIMIT`, 16, consecutive cycles of unchanged `pc` that count as a halt (≥2)
- `DRAIN_CYCLES`, 100, cycles between termination and `done` (≥0)
- `TOHOST_ADDR`, 32'h0000_00FC, store address that terminates the run

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins a run
- `core_rst_n`  out  1  reset to `mips_top`, active low
- `pc`  in  ADDR_W  core program counter
- `mem_we`  in  1  core data-memory write enable
- `mem_addr`  in  ADDR_W  core data-memory address
- `mem_wdata`  in  DATA_W  core data-memory write data
- `busy`  out  1  high in RESET, RUN, DRAIN
- `done`  out  1  high in DONE
- `status`  out  2  00 NONE, 01 PASS, 10 FAIL, 11 TIMEOUT
- `result`  out  DATA_W  tohost data, or `pc` on halt, or 0 on timeout
- `cycle_count`  out  32  RUN cycles elapsed, frozen at termination

## Operation
- FSM states: IDLE → RESET → RUN → DRAIN → DONE.
  - IDLE: waits for `start`.
  - RESET: counts `RST_HOLD` cycles, then goes to RUN.
  - RUN: ends on the first termination event and goes to DRAIN.
  - DRAIN: counts `DRAIN_CYCLES`, then goes to DONE. With `DRAIN_CYCLES`=0 it passes straight through in one cycle.
  - DONE: `start` restarts the run (goes to RESET).
- `start` is ignored in RESET, RUN and DRAIN.
- On entering RESET, `status`, `result` and `cycle_count` clear.
- `core_rst_n` is low in IDLE and RESET, and high in RUN, DRAIN and DONE. The core keeps running after termination; its outputs are ignored.
- Termination events are evaluated only in RUN, in this priority order:
  1. tohost store (`mem_we` && `mem_addr`==`TOHOST_ADDR`): `status`=PASS if `mem_wdata`==1, else FAIL; `result`=`mem_wdata`.
  2. halt (stall counter reaches `STALL_LIMIT`): `status`=FAIL, `result`=`pc`.
  3. watchdog (`cycle_count` reaches `WDOG_CYCLES`): `status`=TIMEOUT, `result`=0.
- Stall counter:
  - resets to 1 on every `pc` change and on entering RUN;
  - the first RUN cycle's `pc` is the comparison baseline;
  - saturates at `STALL_LIMIT`.
- Once set, `status` and `result` are frozen until the next `start` or reset.

## Timing
- Reset values: `core_rst_n`=0, `busy`=0, `done`=0, `status`=00, `result`=0, `cycle_count`=0, state IDLE.
- `start` sampled high at edge k → RESET from k, `busy`=1 after k. `core_rst_n` rises after edge k+`RST_HOLD`.
- `cycle_count` increments once per RUN cycle. The first RUN cycle reads 1.
- A termination event sampled at edge t:
  - `status`, `result` and frozen `cycle_count` are visible after t;
  - `done` rises after edge t+`DRAIN_CYCLES`+1.
- Simultaneous events resolve by the priority above. A tohost store in the same cycle as watchdog expiry yields PASS/FAIL, never TIMEOUT.
- `rst_n` low at any time, including mid-run: all outputs go to reset values immediately (asynchronously), and the state returns to IDLE.
- Stores to `TOHOST_ADDR` outside RUN are ignored.

## Structure
- Package `mips_run_pkg`:
  - `run_state_t` enum: IDLE, RESET, RUN, DRAIN, DONE;
  - `run_status_t` enum: NONE=2'b00, PASS, FAIL, TIMEOUT;
  - the `PASS_CODE`=1 constant.
- Sub-module `mips_run_cnt`: a parametrised-width loadable down-counter with a terminal-count flag, asynchronous active-low reset. It is reused for the RESET hold and the DRAIN timer.
- The watchdog, stall counter and FSM stay in the top module.

## Test plan
- `start`, then a store of 1 to 0xFC at RUN cycle 50 → `status`=01, `result`=1, `cycle_count`=50, `done` 101 cycles later (`DRAIN_CYCLES`=100).
- A store of 0xDEAD to 0xFC → `status`=10, `result`=0xDEAD. A store of 1 to 0xF8 → ignored, the run continues.
- `pc` held at 0x40 from RUN cycle 20 (`STALL_LIMIT`=16) → FAIL, `result`=0x40 at the 16th equal cycle.
- `WDOG_CYCLES`=200, no stores, `pc` incrementing → TIMEOUT, `cycle_count`=200, `result`=0. A tohost store on cycle 200 → PASS instead.
- `rst_n` pulsed low mid-RUN → `core_rst_n`=0 and all outputs zero immediately. A following `start` runs normally; `start` pulses during RUN are ignored; `start` in DONE restarts with `core_rst_n` low for 4 cycles.

Source files
------------

// File: rtl/mips_run_pkg.sv
// Shared types and constants for the MIPS run-control block.
// The FSM state and verdict encodings are visible to the top and any bench that imports them.
package mips_run_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET,
      RUN,
      DRAIN,
      DONE
   } run_state_t;

   typedef enum logic [1:0] {
      NONE    = 2'b00,
      PASS    = 2'b01,
      FAIL    = 2'b10,
      TIMEOUT = 2'b11
   } run_status_t;

   // Value a program stores to tohost to report success.
   localparam int PASS_CODE = 1;

endpackage

// File: rtl/mips_run_cnt.sv
// Loadable down-counter with a terminal-count flag.
// Used for both the core reset hold and the post-termination drain timer.
module mips_run_cnt #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             tc
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // A load wins over a decrement; the count parks at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != '0)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == '0);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run-control and supervision for the MIPS core: sequences core reset, bounds execution
// with a watchdog, detects tohost stores or PC self-loops, and latches a verdict.
module mips_run_ctrl
   import mips_run_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                RST_HOLD     = 4,
   parameter int unsigned       WDOG_CYCLES  = 100000,
   parameter int                STALL_LIMIT  = 16,
   parameter int                DRAIN_CYCLES = 100,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 'h0000_00FC
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              core_rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic [1:0]        status,
   output logic [DATA_W-1:0] result,
   output logic [31:0]       cycle_count
);

   localparam int RST_W = $clog2(RST_HOLD + 1);
   localparam int DRN_W = $clog2(DRAIN_CYCLES + 2);
   localparam int STL_W = $clog2(STALL_LIMIT + 1);

   localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RST_HOLD - 1);
   localparam logic [DRN_W-1:0] DRN_LOAD  = DRN_W'(DRAIN_CYCLES);
   localparam logic [STL_W-1:0] STALL_MAX = STL_W'(STALL_LIMIT);
   localparam logic [31:0]      WDOG_LIM  = 32'(WDOG_CYCLES);

   run_state_t        state_q, state_d;
   run_status_t       status_q, status_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic [STL_W-1:0]  stall_q, stall_d;
   logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;

   logic              rst_load, rst_en, rst_tc;
   logic              drain_load, drain_en, drain_tc;
   logic [STL_W-1:0]  stall_now;
   logic              first_run;
   logic              tohost_hit, halt_hit, wdog_hit;

   mips_run_cnt #(.WIDTH(RST_W)) u_rst_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rst_load),
      .load_val (RST_LOAD),
      .en       (rst_en),
      .tc       (rst_tc)
   );

   mips_run_cnt #(.WIDTH(DRN_W)) u_drain_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (drain_load),
      .load_val (DRN_LOAD),
      .en       (drain_en),
      .tc       (drain_tc)
   );

   // The first RUN cycle (count of 1) only captures the baseline PC.
   always_comb begin
      first_run = (cycle_count_q == 32'd1);
      stall_now = STL_W'(1);
      if (!first_run && (pc == pc_prev_q)) begin
         stall_now = (stall_q == STALL_MAX) ? stall_q : stall_q + STL_W'(1);
      end
      tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
      halt_hit   = (stall_now == STALL_MAX);
      wdog_hit   = (cycle_count_q == WDOG_LIM);
   end

   always_comb begin
      state_d       = state_q;
      status_d      = status_q;
      result_d      = result_q;
      cycle_count_d = cycle_count_q;
      stall_d       = stall_q;
      pc_prev_d     = pc_prev_q;
      rst_load      = 1'b0;
      rst_en        = 1'b0;
      drain_load    = 1'b0;
      drain_en      = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d       = RESET;
               rst_load      = 1'b1;
               status_d      = NONE;
               result_d      = '0;
               cycle_count_d = '0;
            end
         end
         RESET: begin
            if (rst_tc) begin
               state_d       = RUN;
               cycle_count_d = 32'd1;
               stall_d       = STL_W'(1);
            end else begin
               rst_en = 1'b1;
            end
         end
         RUN: begin
            stall_d   = stall_now;
            pc_prev_d = pc;
            // Priority: tohost store, then halt, then watchdog; the count freezes on any.
            if (tohost_hit) begin
               state_d    = DRAIN;
               drain_load = 1'b1;
               status_d   = (mem_wdata == DATA_W'(PASS_CODE)) ? PASS : FAIL;
               result_d   = mem_wdata;
            end else if (halt_hit) begin
               state_d    = DRAIN;
               drain_load = 1'b1;
               status_d   = FAIL;
               result_d   = DATA_W'(pc);
            end else if (wdog_hit) begin
               state_d    = DRAIN;
               drain_load = 1'b1;
               status_d   = TIMEOUT;
               result_d   = '0;
            end else begin
               cycle_count_d = cycle_count_q + 32'd1;
            end
         end
         DRAIN: begin
            if (drain_tc) begin
               state_d = DONE;
            end else begin
               drain_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         status_q      <= NONE;
         result_q      <= '0;
         cycle_count_q <= '0;
         stall_q       <= '0;
         pc_prev_q     <= '0;
      end else begin
         state_q       <= state_d;
         status_q      <= status_d;
         result_q      <= result_d;
         cycle_count_q <= cycle_count_d;
         stall_q       <= stall_d;
         pc_prev_q     <= pc_prev_d;
      end
   end

   assign core_rst_n  = (state_q == RUN) || (state_q == DRAIN) || (state_q == DONE);
   assign busy        = (state_q == RESET) || (state_q == RUN) || (state_q == DRAIN);
   assign done        = (state_q == DONE);
   assign status      = status_q;
   assign result      = result_q;
   assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: per-scenario tasks plus a scoreboard that
// scores the verdict of each run when done rises.
module tb_mips_run_ctrl;

   localparam int HOLD  = 4;
   localparam int DRAIN = 100;
   localparam int WDOG  = 200;
   localparam int STALL = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start0 = 1'b0;
   logic [31:0] pc = 32'h1000;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;

   logic        core_rst_n, busy, done;
   logic [1:0]  status;
   logic [31:0] result, cycle_count;
   logic        core_rst_n0, busy0, done0;
   logic [1:0]  status0;
   logic [31:0] result0, cycle_count0;

   typedef struct {
      string       name;
      logic [1:0]  status;
      logic [31:0] result;
      logic [31:0] cycles;
      int          done_cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   bit   pc_inc = 1'b1;
   logic done_prev = 1'b0;

   always #5 clk = ~clk;

   mips_run_ctrl #(
      .RST_HOLD(HOLD), .WDOG_CYCLES(WDOG), .STALL_LIMIT(STALL), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .core_rst_n(core_rst_n), .pc(pc),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .done(done), .status(status), .result(result), .cycle_count(cycle_count)
   );

   mips_run_ctrl #(
      .RST_HOLD(1), .WDOG_CYCLES(WDOG), .STALL_LIMIT(STALL), .DRAIN_CYCLES(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .core_rst_n(core_rst_n0), .pc(pc),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy0),
      .done(done0), .status(status0), .result(result0), .cycle_count(cycle_count0)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: each rising done retires the oldest expected verdict.
   always @(negedge clk) begin
      if (done && !done_prev) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_done: done rose at cycle %0d, no run pending", cyc);
         end else begin
            mon_e = sb_q.pop_front();
            if (status !== mon_e.status) begin
               n_fail++;
               $display("[TB] FAIL %s_status: got %b expected %b", mon_e.name, status, mon_e.status);
            end
            n_checks++;
            if (result !== mon_e.result) begin
               n_fail++;
               $display("[TB] FAIL %s_result: got %h expected %h", mon_e.name, result, mon_e.result);
            end
            n_checks++;
            if (cycle_count !== mon_e.cycles) begin
               n_fail++;
               $display("[TB] FAIL %s_cycles: got %0d expected %0d", mon_e.name, cycle_count, mon_e.cycles);
            end
            n_checks++;
            if (cyc != mon_e.done_cyc) begin
               n_fail++;
               $display("[TB] FAIL %s_done_time: got %0d expected %0d", mon_e.name, cyc, mon_e.done_cyc);
            end
         end
      end
      done_prev <= done;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         if (pc_inc) pc = pc + 32'd4;
      end
   endtask

   task automatic start_run(output int hold);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      hold = 0;
      while (!core_rst_n && hold < 50) begin
         tick(1);
         hold++;
      end
   endtask

   task automatic wait_done(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !done; i++) tick(1);
      if (done) seen = 1'b1;
   endtask

   task automatic store(input logic [31:0] addr, input logic [31:0] data);
      mem_we = 1'b1;
      mem_addr = addr;
      mem_wdata = data;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_ctrl: core_rst_n/busy/done got %b%b%b expected 000", core_rst_n, busy, done);
      end
      n_checks++;
      if (status !== 2'b00 || result !== 32'd0 || cycle_count !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_data: status %b result %h cycles %0d expected zeros", status, result, cycle_count);
      end
      rst_n = 1'b1;
      tick(1);
      store(32'hFC, 32'd1);
      tick(1);
      mem_we = 1'b0;
      tick(1);
      n_checks++;
      if (status !== 2'b00 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL idle_store: status %b busy %b expected 00 0", status, busy);
      end
   endtask

   task automatic test_pass();
      int hold;
      bit seen;
      start_run(hold);
      n_checks++;
      if (hold != HOLD) begin
         n_fail++;
         $display("[TB] FAIL pass_hold: got %0d expected %0d", hold, HOLD);
      end
      n_checks++;
      if (cycle_count !== 32'd1) begin
         n_fail++;
         $display("[TB] FAIL first_cycle: got %0d expected 1", cycle_count);
      end
      tick(49);
      store(32'hFC, 32'd1);
      sb_q.push_back('{"pass", 2'b01, 32'd1, 32'd50, cyc + 2 + DRAIN});
      tick(1);
      mem_we = 1'b0;
      n_checks++;
      if (status !== 2'b01 || cycle_count !== 32'd50 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL pass_early: status %b cycles %0d busy %b expected 01 50 1", status, cycle_count, busy);
      end
      wait_done(DRAIN + 20, seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL pass_wait: done %b expected 1", done);
      end
      tick(1);
   endtask

   task automatic test_fail_and_ignore();
      int hold;
      bit seen;
      start_run(hold);
      n_checks++;
      if (hold != HOLD) begin
         n_fail++;
         $display("[TB] FAIL restart_hold: got %0d expected %0d", hold, HOLD);
      end
      n_checks++;
      if (status !== 2'b00 || result !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL restart_clear: status %b result %h expected 00 0", status, result);
      end
      tick(9);
      store(32'hF8, 32'd1);
      tick(1);
      mem_we = 1'b0;
      n_checks++;
      if (status !== 2'b00 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL wrong_addr: status %b busy %b expected 00 1", status, busy);
      end
      tick(19);
      store(32'hFC, 32'hDEAD);
      sb_q.push_back('{"fail", 2'b10, 32'hDEAD, 32'd30, cyc + 2 + DRAIN});
      tick(1);
      mem_we = 1'b0;
      wait_done(DRAIN + 20, seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL fail_wait: done %b expected 1", done);
      end
      tick(1);
   endtask

   task automatic test_halt();
      int hold;
      bit seen;
      start_run(hold);
      tick(18);
      pc_inc = 1'b0;
      tick(1);
      pc = 32'h40;
      tick(15);
      n_checks++;
      if (status !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL halt_early: status %b expected 00", status);
      end
      sb_q.push_back('{"halt", 2'b10, 32'h40, 32'd35, cyc + 2 + DRAIN});
      tick(1);
      n_checks++;
      if (status !== 2'b10 || result !== 32'h40) begin
         n_fail++;
         $display("[TB] FAIL halt_now: status %b result %h expected 10 40", status, result);
      end
      wait_done(DRAIN + 20, seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL halt_wait: done %b expected 1", done);
      end
      pc_inc = 1'b1;
      tick(1);
   endtask

   task automatic test_watchdog(input bit with_store);
      int hold;
      bit seen;
      start_run(hold);
      tick(WDOG - 1);
      n_checks++;
      if (cycle_count !== 32'(WDOG) || status !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL wdog_edge: cycles %0d status %b expected %0d 00", cycle_count, status, WDOG);
      end
      if (with_store) begin
         store(32'hFC, 32'd1);
         sb_q.push_back('{"wdog_store", 2'b01, 32'd1, 32'(WDOG), cyc + 2 + DRAIN});
      end else begin
         sb_q.push_back('{"wdog", 2'b11, 32'd0, 32'(WDOG), cyc + 2 + DRAIN});
      end
      tick(1);
      mem_we = 1'b0;
      wait_done(DRAIN + 20, seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL wdog_wait: done %b expected 1", done);
      end
      tick(1);
   endtask

   task automatic test_async_reset();
      int hold;
      start_run(hold);
      tick(10);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 ||
          result !== 32'd0 || cycle_count !== 32'd0) begin
         n_fail++;
         $display("[TB] FAIL async_reset: core %b busy %b done %b status %b result %h cycles %0d expected zeros",
                  core_rst_n, busy, done, status, result, cycle_count);
      end
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_back_to_back();
      int hold;
      bit seen;
      start_run(hold);
      n_checks++;
      if (hold != HOLD) begin
         n_fail++;
         $display("[TB] FAIL b2b_hold: got %0d expected %0d", hold, HOLD);
      end
      tick(5);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      n_checks++;
      if (cycle_count !== 32'd7 || core_rst_n !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL start_in_run: cycles %0d core %b busy %b expected 7 1 1", cycle_count, core_rst_n, busy);
      end
      tick(5);
      store(32'hFC, 32'd1);
      sb_q.push_back('{"b2b", 2'b01, 32'd1, 32'd12, cyc + 2 + DRAIN});
      tick(1);
      mem_we = 1'b0;
      wait_done(DRAIN + 20, seen);
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("[TB] FAIL b2b_wait: done %b expected 1", done);
      end
      tick(1);
   endtask

   task automatic test_drain_zero();
      int hold;
      start0 = 1'b1;
      tick(1);
      start0 = 1'b0;
      hold = 0;
      while (!core_rst_n0 && hold < 50) begin
         tick(1);
         hold++;
      end
      n_checks++;
      if (hold != 1 || cycle_count0 !== 32'd1) begin
         n_fail++;
         $display("[TB] FAIL d0_hold: hold %0d cycles %0d expected 1 1", hold, cycle_count0);
      end
      tick(2);
      store(32'hFC, 32'd5);
      tick(1);
      mem_we = 1'b0;
      n_checks++;
      if (status0 !== 2'b10 || result0 !== 32'd5 || cycle_count0 !== 32'd3 || done0 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL d0_term: status %b result %h cycles %0d done %b expected 10 5 3 0",
                  status0, result0, cycle_count0, done0);
      end
      tick(1);
      n_checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL d0_done: done %b busy %b expected 1 0", done0, busy0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL global_timeout: simulation exceeded its time budget");
      $fatal(1, "[TB] time budget exhausted");
   end

   initial begin
      test_reset();
      test_pass();
      test_fail_and_ignore();
      test_halt();
      test_watchdog(1'b0);
      test_watchdog(1'b1);
      test_async_reset();
      test_back_to_back();
      test_drain_zero();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL scoreboard_drain: %0d runs left expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
